// File: rtl/dpa_pkg.sv
// Shared types and helpers for the DPA link trainer: state codes and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpa_pkg;

  // Default lane count: 4 data lanes plus the control lane of an RGMII-style link.
  localparam int DEF_NUM_LANES = 5;

  // Width of the debug state code driven out of the trainer.
  localparam int ST_W = 3;

  // State codes are visible on state_o, so they are fixed rather than left to the tool.
  typedef enum logic [ST_W-1:0] {
    ST_RESET  = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  // Counter width: enough to hold the largest cycle parameter, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dpa_link_trainer_if.sv
// Bundles the trainer's lane-status inputs and PHY/pattern/monitor control outputs.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle strobes.
interface dpa_link_trainer_if #(
  parameter int NUM_LANES = dpa_pkg::DEF_NUM_LANES
) ();
  import dpa_pkg::*;

  logic [NUM_LANES-1:0] lane_done;
  logic                 retrain_req;
  logic                 phy_reset_n;
  logic                 tx_pattern_en;
  logic                 train_rst;
  logic                 link_up;
  logic                 link_fail;
  logic [3:0]           retry_cnt;
  logic [ST_W-1:0]      state_o;

  // Trainer side: consumes lane status, drives PHY and training control.
  modport master (
    input  lane_done, retrain_req,
    output phy_reset_n, tx_pattern_en, train_rst, link_up, link_fail, retry_cnt, state_o
  );

  // Environment side: PHY, pattern generator, training monitor and supervisor.
  modport slave (
    output lane_done, retrain_req,
    input  phy_reset_n, tx_pattern_en, train_rst, link_up, link_fail, retry_cnt, state_o
  );

endinterface

// File: rtl/dpa_sync_bus.sv
// Multi-flop synchroniser for a bus of independent asynchronous level flags.
// Latency: STAGES clk cycles from d_i to q_o.
// Backpressure: none; each bit is sampled every cycle, no handshake.
module dpa_sync_bus #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift each lane flag through the flop chain; reset flushes stale lane state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dpa_link_trainer.sv
// PHY bring-up and deskew-training sequencer: reset, settle, train, lock, retry and fail.
// Latency: lane_done reaches the FSM after SYNC_STAGES cycles; outputs are registered (+1).
// Backpressure: none; retrain_req is a single-cycle strobe honoured in any state.
module dpa_link_trainer
  import dpa_pkg::*;
#(
  parameter int NUM_LANES     = DEF_NUM_LANES,
  parameter int RESET_CYCLES  = 25_000_000,
  parameter int SETTLE_CYCLES = 32,
  parameter int TRAIN_TIMEOUT = 1_000_000,
  parameter int LOSS_CYCLES   = 16,
  parameter int MAX_RETRY     = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  dpa_link_trainer_if.master bus
);

  localparam int CNT_W = cnt_width(RESET_CYCLES, SETTLE_CYCLES, TRAIN_TIMEOUT, LOSS_CYCLES);

  // Terminal counts: the phase counter starts at 0 on every state entry.
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETL_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST  = CNT_W'(LOSS_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

  logic [NUM_LANES-1:0] lane_sync;
  logic                 all_done;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     loss_q;
  logic [3:0]           retry_q;
  logic [3:0]           retry_d;
  logic                 phy_reset_n_q;
  logic                 tx_pattern_en_q;
  logic                 train_rst_q;
  logic                 link_up_q;
  logic                 link_fail_q;

  dpa_sync_bus #(
    .WIDTH  (NUM_LANES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.lane_done),
    .q_o (lane_sync)
  );

  assign all_done = &lane_sync;

  // Retry count after one more failed attempt; saturates so it can never wrap past the limit.
  always_comb begin
    retry_d = retry_q;
    if (retry_q < RETRY_MAX) retry_d = retry_q + 4'd1;
  end

  // Training sequencer: state, shared phase counter, loss counter, retry count and all outputs.
  always_ff @(posedge clk) begin
    if (rst || bus.retrain_req) begin
      // A retrain request is a full restart, identical to reset apart from the synchroniser.
      state_q         <= ST_RESET;
      cnt_q           <= '0;
      loss_q          <= '0;
      retry_q         <= '0;
      phy_reset_n_q   <= 1'b0;
      tx_pattern_en_q <= 1'b0;
      train_rst_q     <= 1'b1;
      link_up_q       <= 1'b0;
      link_fail_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_q       <= ST_SETTLE;
            cnt_q         <= '0;
            phy_reset_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == SETL_LAST) begin
            state_q         <= ST_TRAIN;
            cnt_q           <= '0;
            tx_pattern_en_q <= 1'b1;
            train_rst_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_TRAIN: begin
          // Ends the one-cycle monitor reset issued on a lock-loss re-entry.
          train_rst_q <= 1'b0;
          if (all_done) begin
            // Lock takes precedence over a timeout landing in the same cycle.
            state_q   <= ST_LOCKED;
            cnt_q     <= '0;
            loss_q    <= '0;
            link_up_q <= 1'b1;
          end else if (cnt_q == TOUT_LAST) begin
            cnt_q           <= '0;
            retry_q         <= retry_d;
            tx_pattern_en_q <= 1'b0;
            train_rst_q     <= 1'b1;
            if (retry_d == RETRY_MAX) begin
              // Give up: PHY is left out of reset so it can be inspected.
              state_q     <= ST_FAIL;
              link_fail_q <= 1'b1;
            end else begin
              state_q       <= ST_RESET;
              phy_reset_n_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (all_done) begin
            loss_q <= '0;
          end else if (loss_q == LOSS_LAST) begin
            // Sustained loss: retrain without a PHY reset and without charging a retry.
            state_q     <= ST_TRAIN;
            cnt_q       <= '0;
            loss_q      <= '0;
            link_up_q   <= 1'b0;
            train_rst_q <= 1'b1;
          end else begin
            loss_q <= loss_q + 1'b1;
          end
        end

        ST_FAIL: begin
          // Parked until rst or retrain_req.
        end

        default: begin
          state_q         <= ST_RESET;
          cnt_q           <= '0;
          loss_q          <= '0;
          phy_reset_n_q   <= 1'b0;
          tx_pattern_en_q <= 1'b0;
          train_rst_q     <= 1'b1;
          link_up_q       <= 1'b0;
          link_fail_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phy_reset_n   = phy_reset_n_q;
  assign bus.tx_pattern_en = tx_pattern_en_q;
  assign bus.train_rst     = train_rst_q;
  assign bus.link_up       = link_up_q;
  assign bus.link_fail     = link_fail_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_dpa_link_trainer.sv
// Self-checking bench for dpa_link_trainer: directed bring-up scenarios plus randomized lane traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_dpa_link_trainer;

  localparam int NL = 5;
  localparam int RC = 10;
  localparam int SC = 4;
  localparam int TT = 20;
  localparam int LC = 3;
  localparam int MR = 2;
  localparam int SS = 2;

  // Phase codes as published on state_o.
  localparam int P_RESET  = 0;
  localparam int P_SETTLE = 1;
  localparam int P_TRAIN  = 2;
  localparam int P_LOCKED = 3;
  localparam int P_FAIL   = 4;

  localparam logic [NL-1:0] ALL1 = {NL{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dpa_link_trainer_if #(.NUM_LANES(NL)) bus ();

  dpa_link_trainer #(
    .NUM_LANES     (NL),
    .RESET_CYCLES  (RC),
    .SETTLE_CYCLES (SC),
    .TRAIN_TIMEOUT (TT),
    .LOSS_CYCLES   (LC),
    .MAX_RETRY     (MR),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase, cycles spent in phase, consecutive bad cycles, failed attempts.
  logic [NL-1:0] m_pipe[$];
  int m_phase = P_RESET;
  int m_t     = 0;
  int m_bad   = 0;
  int m_retry = 0;
  bit m_pulse = 1'b0;

  task automatic model_step(input bit r, input bit req, input logic [NL-1:0] lanes);
    logic [NL-1:0] seen;
    bit all;
    if (r) begin
      m_pipe.delete();
      repeat (SS) m_pipe.push_back('0);
      m_phase = P_RESET; m_t = 0; m_bad = 0; m_retry = 0; m_pulse = 1'b0;
      return;
    end
    // What the FSM sees now is what the pins carried SS edges ago.
    seen = m_pipe.pop_front();
    m_pipe.push_back(lanes);
    all = (seen == ALL1);
    m_pulse = 1'b0;
    if (req) begin
      m_phase = P_RESET; m_t = 0; m_bad = 0; m_retry = 0;
      return;
    end
    case (m_phase)
      P_RESET: begin
        m_t++;
        if (m_t == RC) begin m_phase = P_SETTLE; m_t = 0; end
      end
      P_SETTLE: begin
        m_t++;
        if (m_t == SC) begin m_phase = P_TRAIN; m_t = 0; end
      end
      P_TRAIN: begin
        m_t++;
        if (all) begin
          m_phase = P_LOCKED; m_t = 0; m_bad = 0;
        end else if (m_t == TT) begin
          m_retry = (m_retry + 1 > MR) ? MR : m_retry + 1;
          m_phase = (m_retry == MR) ? P_FAIL : P_RESET;
          m_t = 0;
        end
      end
      P_LOCKED: begin
        m_bad = all ? 0 : m_bad + 1;
        if (m_bad == LC) begin
          m_phase = P_TRAIN; m_t = 0; m_bad = 0; m_pulse = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare outputs.
  task automatic step();
    bit tx_on;
    @(posedge clk);
    model_step(rst, bus.retrain_req, bus.lane_done);
    #1;
    tx_on = (m_phase == P_TRAIN) || (m_phase == P_LOCKED);
    check("state",         32'(bus.state_o),       32'(m_phase));
    check("phy_reset_n",   32'(bus.phy_reset_n),   32'(m_phase != P_RESET));
    check("tx_pattern_en", 32'(bus.tx_pattern_en), 32'(tx_on));
    check("train_rst",     32'(bus.train_rst),     32'(!tx_on || m_pulse));
    check("link_up",       32'(bus.link_up),       32'(m_phase == P_LOCKED));
    check("link_fail",     32'(bus.link_fail),     32'(m_phase == P_FAIL));
    check("retry_cnt",     32'(bus.retry_cnt),     32'(m_retry));
  endtask

  task automatic wait_state(input int code, input int budget);
    int n;
    n = 0;
    while (int'(bus.state_o) != code && n < budget) begin
      step();
      n++;
    end
    if (int'(bus.state_o) != code) check("wait_state", 32'(bus.state_o), 32'(code));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(bus.state_o),       32'(P_RESET));
    check({tag, "_phy"},   32'(bus.phy_reset_n),   32'd0);
    check({tag, "_pat"},   32'(bus.tx_pattern_en), 32'd0);
    check({tag, "_trst"},  32'(bus.train_rst),     32'd1);
    check({tag, "_up"},    32'(bus.link_up),       32'd0);
    check({tag, "_fail"},  32'(bus.link_fail),     32'd0);
    check({tag, "_retry"}, 32'(bus.retry_cnt),     32'd0);
  endtask

  // Cycles from the last reset sample until phy_reset_n is first seen high.
  task automatic count_reset_hold(output int n);
    n = 0;
    while (!bus.phy_reset_n && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int k;
    logic [NL-1:0] lanes;

    bus.lane_done   = '0;
    bus.retrain_req = 1'b0;

    // 1. Happy path.
    rst = 1'b1;
    step();
    step();
    check_reset_vals("rst");
    rst = 1'b0;
    count_reset_hold(n);
    check("reset_hold", 32'(n), 32'(RC));
    while (!bus.tx_pattern_en && n < 80) begin
      step();
      n++;
    end
    check("pattern_en_cycle", 32'(n), 32'(RC + SC));
    repeat (5) step();
    bus.lane_done = ALL1;
    k = 0;
    while (!bus.link_up && k < 20) begin
      step();
      k++;
    end
    check("lock_latency", 32'(k), 32'(SS + 1));
    check("happy_retry", 32'(bus.retry_cnt), 32'd0);

    // 3. Lock loss: short glitch ignored, sustained drop retrains.
    bus.lane_done = 5'h1B;
    repeat (2) step();
    bus.lane_done = ALL1;
    repeat (6) step();
    check("glitch_link_up", 32'(bus.link_up), 32'd1);
    bus.lane_done = 5'h1B;
    repeat (3) step();
    bus.lane_done = ALL1;
    wait_state(P_TRAIN, 10);
    check("loss_link_up", 32'(bus.link_up), 32'd0);
    check("loss_train_rst", 32'(bus.train_rst), 32'd1);
    check("loss_retry", 32'(bus.retry_cnt), 32'd0);
    step();
    check("loss_pulse_end", 32'(bus.train_rst), 32'd0);
    wait_state(P_LOCKED, 20);

    // 2. Timeout, retry, then hard fail.
    bus.lane_done = 5'h0F;
    wait_state(P_TRAIN, 20);
    n = 0;
    while (int'(bus.state_o) == P_TRAIN && n < 100) begin
      step();
      n++;
    end
    check("train_len", 32'(n), 32'(TT));
    check("to_retry", 32'(bus.retry_cnt), 32'd1);
    check("to_phy", 32'(bus.phy_reset_n), 32'd0);
    wait_state(P_FAIL, 200);
    check("fail_flag", 32'(bus.link_fail), 32'd1);
    check("fail_retry", 32'(bus.retry_cnt), 32'(MR));
    repeat (100) step();
    check("fail_held", 32'(bus.state_o), 32'(P_FAIL));

    // 5. retrain_req from FAIL and from mid-TRAIN.
    bus.retrain_req = 1'b1;
    step();
    bus.retrain_req = 1'b0;
    check_reset_vals("req_fail");
    wait_state(P_TRAIN, 50);
    repeat (5) step();
    bus.retrain_req = 1'b1;
    step();
    bus.retrain_req = 1'b0;
    check_reset_vals("req_train");

    // 4. all_done reaches the FSM on the very timeout cycle.
    wait_state(P_TRAIN, 50);
    repeat (TT - SS - 1) step();
    bus.lane_done = ALL1;
    repeat (SS + 1) step();
    check("tie_state", 32'(bus.state_o), 32'(P_LOCKED));
    check("tie_retry", 32'(bus.retry_cnt), 32'd0);

    // 6. rst mid-SETTLE together with retrain_req.
    bus.retrain_req = 1'b1;
    step();
    bus.retrain_req = 1'b0;
    wait_state(P_SETTLE, 50);
    repeat (2) step();
    rst = 1'b1;
    bus.retrain_req = 1'b1;
    step();
    check_reset_vals("rst_settle");
    rst = 1'b0;
    bus.retrain_req = 1'b0;
    count_reset_hold(n);
    check("reset_hold2", 32'(n), 32'(RC));

    // Randomized lane activity with occasional retrain requests and resets.
    lanes = ALL1;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) lanes = ALL1;
        else lanes = NL'($urandom);
      end
      bus.lane_done   = lanes;
      bus.retrain_req = ($urandom_range(0, 299) == 0);
      rst             = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    bus.retrain_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
